// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the I2S transmit path.
package audio_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int CH_W      = 16;
  localparam int I2S_SLOTS = 32;
  localparam int SLOT_W    = $clog2(I2S_SLOTS);

  // Word select for a slot: left channel occupies the first half of the frame.
  function automatic logic lrck_for_slot(input logic [SLOT_W-1:0] slot);
    return (slot >= SLOT_W'(CH_W));
  endfunction

endpackage

// File: rtl/audio_tx_fifo.sv
// Single-clock sample buffer with registered level/full/empty flags.
module audio_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_s, pop_s;

  // Qualify requests against the registered flags; pointers wrap naturally.
  always_comb begin
    push_s   = wr_en_i & ~full_q;
    pop_s    = rd_en_i & ~empty_q;
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == LW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; only words behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers stereo words and serialises them MSB first
// with the one-bit I2S delay; all serial outputs change on BCLK falls.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          i2s_bclk,
  output logic                          i2s_lrck,
  output logic                          i2s_sdata,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                lrck_q, lrck_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                underrun_q, underrun_d;

  logic                wrap_s, fall_s, load_s, pop_s;
  logic [SAMPLE_W-1:0] fifo_head_s;
  logic                fifo_full_s, fifo_empty_s;

  audio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (sample_valid),
    .wr_data_i (sample_in),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_head_s),
    .level_o   (fifo_level),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  // Leaving slot 0 is the frame boundary: the next word enters the shifter there.
  always_comb begin
    wrap_s     = (div_q == DIV_W'(BCLK_DIV - 1));
    fall_s     = wrap_s & bclk_q;
    load_s     = fall_s & (slot_q == SLOT_W'(0));
    pop_s      = load_s & ~fifo_empty_s;
    div_d      = wrap_s ? DIV_W'(0) : (div_q + DIV_W'(1));
    bclk_d     = wrap_s ? ~bclk_q : bclk_q;
    underrun_d = load_s & fifo_empty_s;
    slot_d     = slot_q;
    lrck_d     = lrck_q;
    shift_d    = shift_q;
    if (fall_s) begin
      slot_d = slot_q + SLOT_W'(1);
      lrck_d = lrck_for_slot(slot_d);
      if (load_s) begin
        if (fifo_empty_s) begin
          shift_d = SAMPLE_W'(0);
        end else begin
          shift_d = fifo_head_s;
        end
      end else begin
        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
      end
    end else begin
      slot_d  = slot_q;
      lrck_d  = lrck_q;
      shift_d = shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DIV_W'(0);
      bclk_q     <= 1'b0;
      slot_q     <= SLOT_W'(0);
      lrck_q     <= 1'b0;
      shift_q    <= SAMPLE_W'(0);
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      lrck_q     <= lrck_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_ready = ~fifo_full_s;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_sdata    = shift_q[SAMPLE_W-1];
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx against a frame-level reference model.
module tb_audio_i2s_tx;

  localparam int D     = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_sdata;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  audio_i2s_tx #(
    .BCLK_DIV   (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: clk edges since reset release, buffered words, word on the wire.
  int          edge_n;
  logic [31:0] mq[$];
  logic [31:0] cur_w;
  logic        exp_underrun;
  bit          last_fall;
  bit          last_load;

  bit          cap_en;
  int          cap_cnt;
  logic [31:0] cap_w;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic int cur_slot();
    return (edge_n / (2 * D)) % 32;
  endfunction

  function automatic bit next_is_load();
    return (((edge_n + 1) % (2 * D)) == 0) && ((((edge_n + 1) / (2 * D)) % 32) == 1);
  endfunction

  task automatic model_reset();
    edge_n       = 0;
    mq.delete();
    cur_w        = 32'h0;
    exp_underrun = 1'b0;
    last_fall    = 1'b0;
    last_load    = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d);
    bit do_push;
    edge_n++;
    exp_underrun = 1'b0;
    last_fall    = ((edge_n % (2 * D)) == 0);
    last_load    = last_fall && (cur_slot() == 1);
    do_push      = v && (mq.size() != DEPTH);
    if (last_load) begin
      if (mq.size() == 0) begin
        cur_w        = 32'h0;
        exp_underrun = 1'b1;
      end else begin
        cur_w = mq.pop_front();
      end
    end
    if (do_push) mq.push_back(d);
  endtask

  task automatic check_outputs();
    int s;
    s = cur_slot();
    check_val("bclk",     32'(i2s_bclk),     32'((edge_n / D) % 2));
    check_val("lrck",     32'(i2s_lrck),     32'(s >= 16));
    check_val("sdata",    32'(i2s_sdata),    32'(cur_w[(32 - s) % 32]));
    check_val("underrun", 32'(underrun),     32'(exp_underrun));
    check_val("level",    32'(fifo_level),   32'(mq.size()));
    check_val("ready",    32'(sample_ready), 32'(mq.size() != DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    last_fall = 1'b0;
    last_load = 1'b0;
    if (rst_n) model_edge(sample_valid, sample_in);
    #1;
    check_outputs();
    if (cap_en && last_fall) begin
      cap_w = {cap_w[30:0], i2s_sdata};
      cap_cnt++;
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_sdata", 32'(i2s_sdata),  32'd0);
  endtask

  task automatic wait_before_load(input string tag);
    int i;
    for (i = 0; i < 300 && !next_is_load(); i++) step();
    check_val(tag, 32'(next_is_load()), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 32'h0;
    cap_en       = 1'b0;
    cap_cnt      = 0;
    cap_w        = 32'h0;
    model_reset();
    repeat (4) step();

    // Serial format of one known word, then empty frames.
    rst_n        = 1'b1;
    cap_en       = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 32'hA5A5_3C3C;
    step();
    sample_valid = 1'b0;
    for (int i = 0; i < 400 && cap_cnt < 32; i++) step();
    cap_en = 1'b0;
    check_val("cap_count",  32'(cap_cnt),      32'd32);
    check_val("left_bits",  32'(cap_w[31:16]), 32'h0000_A5A5);
    check_val("right_bits", 32'(cap_w[15:0]),  32'h0000_3C3C);
    repeat (256) step();

    // Five back-to-back pushes into an empty buffer, clear of any load.
    for (int i = 0; i < 300 && !last_load; i++) step();
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in    = $urandom;
      step();
    end
    sample_valid = 1'b0;
    check_val("full_level", 32'(fifo_level),   32'd4);
    check_val("full_ready", 32'(sample_ready), 32'd0);

    // Push while full on a load edge: dropped, level falls to 3.
    wait_before_load("reach_load_full");
    sample_valid = 1'b1;
    sample_in    = $urandom;
    step();
    sample_valid = 1'b0;
    check_val("pop_drop_level", 32'(fifo_level), 32'd3);

    // Drain one, then push and pop together at level 2.
    wait_before_load("reach_load_3");
    step();
    wait_before_load("reach_load_2");
    sample_valid = 1'b1;
    sample_in    = $urandom;
    step();
    sample_valid = 1'b0;
    check_val("push_pop_level", 32'(fifo_level), 32'd2);
    repeat (300) step();

    // Random traffic against the model.
    repeat (1024) begin
      sample_valid = ($urandom_range(0, 99) < 3);
      sample_in    = $urandom;
      step();
    end
    sample_valid = 1'b0;

    // Reset mid-frame with three words buffered.
    async_reset();
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in    = $urandom;
      step();
    end
    sample_valid = 1'b0;
    check_val("pre_rst_level", 32'(fifo_level), 32'd3);
    for (int i = 0; i < 300 && cur_slot() != 10; i++) step();
    check_val("slot10_reached", 32'(cur_slot()), 32'd10);
    async_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (260) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
